// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl
//   Turns a raw, bouncy pedestrian pushbutton into a clean request level for
//   the traffic light controller. The request is held until the light shows
//   red, and a cooldown window follows each served request.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   button_raw_i   raw pushbutton (asynchronous to clk_i, bouncy)
//   red_i          red lamp from the traffic light; high = pedestrian phase served
//   request_o      registered pedestrian request level
//   busy_o         high while in cooldown
//   press_count_o  accepted request count, saturating at 255
module ped_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,   // 1..255
  parameter int unsigned COOLDOWN_CYCLES = 20   // 0..255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       button_raw_i,
  input  logic       red_i,
  output logic       request_o,
  output logic       busy_o,
  output logic [7:0] press_count_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQUEST  = 2'd1;
  localparam logic [1:0] S_SERVING  = 2'd2;
  localparam logic [1:0] S_COOLDOWN = 2'd3;

  localparam logic [7:0] DEB_N = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] CD_N  = 8'(COOLDOWN_CYCLES);

  logic       sync_q1, sync_q2;
  logic [7:0] deb_cnt_q;
  logic       deb_lvl_q, deb_lvl_d1_q;
  logic       press_evt;
  logic [1:0] state_q, state_d;
  logic [7:0] cd_q, cd_d;

  // Two-flop synchroniser; nothing downstream sees button_raw_i directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= button_raw_i;
      sync_q2 <= sync_q1;
    end
  end

  // Debouncer: counter runs only while the synchronised level disagrees with
  // the debounced level; the level flips on the edge the count would hit N.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_cnt_q    <= 8'd0;
      deb_lvl_q    <= 1'b0;
      deb_lvl_d1_q <= 1'b0;
    end else begin
      deb_lvl_d1_q <= deb_lvl_q;
      if (sync_q2 == deb_lvl_q) begin
        deb_cnt_q <= 8'd0;
      end else if (deb_cnt_q + 8'd1 == DEB_N) begin
        deb_lvl_q <= sync_q2;
        deb_cnt_q <= 8'd0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 8'd1;
      end
    end
  end

  // One pulse per debounced rising edge, so a held button fires once.
  assign press_evt = deb_lvl_q & ~deb_lvl_d1_q;

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    case (state_q)
      S_IDLE:    if (press_evt) state_d = S_REQUEST;
      S_REQUEST: if (red_i) state_d = S_SERVING;
      S_SERVING: begin
        if (!red_i) begin
          if (COOLDOWN_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_COOLDOWN;
            cd_d    = CD_N;
          end
        end
      end
      default: begin
        // Leaving on the edge the count would reach zero keeps busy_o high
        // for exactly COOLDOWN_CYCLES cycles. Presses here are dropped,
        // including one landing on the exit edge.
        if (cd_q <= 8'd1) begin
          state_d = S_IDLE;
          cd_d    = 8'd0;
        end else begin
          cd_d = cd_q - 8'd1;
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they switch on the same
  // edge as the FSM with no combinational path to the pins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      cd_q          <= 8'd0;
      request_o     <= 1'b0;
      busy_o        <= 1'b0;
      press_count_o <= 8'd0;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      request_o <= (state_d == S_REQUEST);
      busy_o    <= (state_d == S_COOLDOWN);
      if (state_q == S_IDLE && press_evt && press_count_o != 8'hFF)
        press_count_o <= press_count_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_ped_request_ctrl.sv
module tb_ped_request_ctrl;

  localparam int K_RISE = 0;  // request_o rose: val = cycles since mark
  localparam int K_FALL = 1;  // request_o fell: val = cycles it was high
  localparam int K_BUSY = 2;  // busy_o fell:    val = cycles it was high

  typedef struct {
    int kind;
    int val;
    int cnt;
  } ev_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       button_raw_i = 1'b0;
  logic       red_i = 1'b0;
  logic       request_o, busy_o;
  logic [7:0] press_count_o;

  logic       btn0 = 1'b0;
  logic       red0 = 1'b0;
  logic       req0, busy0;
  logic [7:0] cnt0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mark = 0;
  int rise_cyc = 0;
  int busy_start = 0;
  logic prev_req = 1'b0;
  logic prev_busy = 1'b0;
  logic seen_busy0 = 1'b0;
  ev_t exp_q[$];

  ped_request_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .button_raw_i(button_raw_i), .red_i(red_i),
    .request_o(request_o), .busy_o(busy_o), .press_count_o(press_count_o)
  );

  ped_request_ctrl #(.DEBOUNCE_CYCLES(1), .COOLDOWN_CYCLES(0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .button_raw_i(btn0), .red_i(red0),
    .request_o(req0), .busy_o(busy0), .press_count_o(cnt0)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int val, input int cnt);
    ev_t e;
    e.kind = kind; e.val = val; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input int val, input int cnt);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_event: got kind %0d val %0d cnt %0d, none expected (cycle %0d)",
               kind, val, cnt, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_val", val, e.val);
      if (e.kind == K_RISE) chk("press_count", cnt, e.cnt);
    end
  endtask

  // Monitor: decoupled from stimulus, turns output edges into events.
  always @(negedge clk_i) begin
    if (busy0) seen_busy0 = 1'b1;
    if (!rst_ni) begin
      prev_req  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (request_o && !prev_req) begin
        got_ev(K_RISE, cyc - mark, int'(press_count_o));
        rise_cyc = cyc;
      end
      if (!request_o && prev_req) got_ev(K_FALL, cyc - rise_cyc, 0);
      if (busy_o && !prev_busy) busy_start = cyc;
      if (!busy_o && prev_busy) got_ev(K_BUSY, cyc - busy_start, 0);
      prev_req  = request_o;
      prev_busy = busy_o;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  // Raise the button now; request expected 7 edges later.
  task automatic press(input int cnt);
    expect_ev(K_RISE, 7, cnt);
    button_raw_i = 1'b1;
    mark = cyc;
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_request", int'(request_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_count", int'(press_count_o), 0);
    rst_ni = 1'b1;
    step(3);

    // 3-cycle pulse: filtered out
    button_raw_i = 1'b1; step(3);
    button_raw_i = 1'b0; step(20);

    // Clean press, red rises 10 cycles after request
    press(1); step(17);
    red_i = 1'b1; expect_ev(K_FALL, 11, 0);
    step(3); button_raw_i = 1'b0; step(10);
    // Cooldown with an ignored press inside it
    red_i = 1'b0; expect_ev(K_BUSY, 20, 0);
    step(2); button_raw_i = 1'b1;
    step(10); button_raw_i = 1'b0;
    step(18);
    // Press after busy falls
    press(2); step(10);
    red_i = 1'b1; expect_ev(K_FALL, 4, 0);
    button_raw_i = 1'b0; step(10);
    // Press event lands on the COOLDOWN->IDLE edge: dropped, held button no refire
    red_i = 1'b0; expect_ev(K_BUSY, 20, 0);
    step(14); button_raw_i = 1'b1;
    step(20); button_raw_i = 1'b0; step(10);

    // Bounce: toggle every 2 cycles for 20 cycles, then settle high
    for (int i = 0; i < 10; i++) begin
      button_raw_i = (i % 2 == 0);
      step(2);
    end
    press(3); step(12);
    red_i = 1'b1; expect_ev(K_FALL, 6, 0);
    button_raw_i = 1'b0; step(10);
    red_i = 1'b0; expect_ev(K_BUSY, 20, 0);
    step(25);

    // red_i already high: request lasts one cycle
    red_i = 1'b1; step(2);
    press(4); expect_ev(K_FALL, 1, 0);
    step(15); button_raw_i = 1'b0; step(5);
    red_i = 1'b0; expect_ev(K_BUSY, 20, 0);
    step(25);

    // Reset mid-cooldown with button held
    press(5); step(10);
    red_i = 1'b1; expect_ev(K_FALL, 4, 0);
    step(3); red_i = 1'b0; step(5);
    chk("busy_in_cooldown", int'(busy_o), 1);
    rst_ni = 1'b0; #1;
    chk("async_rst_busy", int'(busy_o), 0);
    chk("async_rst_count", int'(press_count_o), 0);
    step(3);
    chk("rst_hold_request", int'(request_o), 0);
    rst_ni = 1'b1;
    expect_ev(K_RISE, 7, 1); mark = cyc;
    step(10);
    red_i = 1'b1; expect_ev(K_FALL, 4, 0);
    button_raw_i = 1'b0; step(10);
    red_i = 1'b0; expect_ev(K_BUSY, 20, 0);
    step(25);
    chk("events_pending", exp_q.size(), 0);

    // Saturation on the zero-cooldown instance
    for (int i = 0; i < 260; i++) begin
      btn0 = 1'b1; step(5);
      if (i == 0 || i == 259) chk("sat_request", int'(req0), 1);
      red0 = 1'b1; step(1);
      red0 = 1'b0; btn0 = 1'b0; step(1);
      step(4);
      chk("sat_count", int'(cnt0), (i + 1 > 255) ? 255 : i + 1);
    end
    chk("sat_no_busy", int'(seen_busy0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
